// File: rtl/alu_div_seq.sv
// Sequential restoring divider (one quotient bit per clock), signed/unsigned.
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] hilo,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_sub;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             early;

    always_comb begin
        dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
        a_sh    = {a[WIDTH-1:0], q[WIDTH-1]};
        a_sub   = a_sh - {1'b0, m};
        q_fix   = sign_q ? -q : q;
        r_fix   = sign_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
`ifdef DIV_EARLY_OUT_EN
        early   = (dvd_mag < dvs_mag);
`else
        early   = 1'b0;
`endif
    end

    assign hilo = {remainder, quotient};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        m      <= dvs_mag;
                        cnt    <= '0;
                        sign_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= signed_op & dividend[WIDTH-1];
                        if (divisor == '0) begin
                            // Raw dividend passes through as the remainder
                            a      <= {1'b0, dividend};
                            q      <= '1;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                            dz     <= 1'b1;
                            state  <= FIX;
                        end else if (early) begin
                            a     <= {1'b0, dvd_mag};
                            q     <= '0;
                            dz    <= 1'b0;
                            state <= FIX;
                        end else begin
                            a     <= '0;
                            q     <= dvd_mag;
                            dz    <= 1'b0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (a_sub[WIDTH]) begin
                        a <= a_sh;
                        q <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        a <= a_sub;
                        q <= {q[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq (WIDTH=32); honours DIV_EARLY_OUT_EN.
// Expected results are queued at start and compared when done pulses.
module tb_alu_div_seq;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_op = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic [2*W-1:0] hilo;
    logic           div_by_zero;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .signed_op(signed_op),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .hilo(hilo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           c0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mag(input bit s, input logic [W-1:0] x);
        return (s && x[W-1]) ? -x : x;
    endfunction

    function automatic int lat_of(input bit s, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
        if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(s, a) < mag(s, b)) return 1;
`endif
        return W + 1;
    endfunction

    function automatic exp_t model(input bit s, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        e.c0 = 0;
        e.lat = lat_of(s, a, b);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
        end else if (s && a == MIN && b == '1) begin
            e.q = MIN;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", {32'b0, quotient}, {32'b0, e.q});
                check("remainder", {32'b0, remainder}, {32'b0, e.r});
                check("hilo", hilo, {e.r, e.q});
                check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dz});
                check("latency", 64'(cyc - e.c0), 64'(e.lat));
                check("busy_at_done", {63'b0, busy}, 64'd0);
                check("done_pulse", {63'b0, prev_done}, 64'd0);
            end
        end
        prev_done <= done;
    end

    // Called at a negedge; holds start across exactly one rising edge.
    task automatic start_op(input bit s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input exp_t e);
        signed_op = s;
        dividend = a;
        divisor = b;
        start = 1'b1;
        e.c0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        signed_op = ~s;
        check("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic op_exp(input bit s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input bit edz);
        exp_t e;
        e.q = eq;
        e.r = er;
        e.dz = edz;
        e.lat = lat_of(s, a, b);
        e.c0 = 0;
        start_op(s, a, b, e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_quotient", {32'b0, quotient}, 64'd0);
        check("rst_remainder", {32'b0, remainder}, 64'd0);
        check("rst_hilo", hilo, 64'd0);
        check("rst_dz", {63'b0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op_exp(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);            drain(50);
        op_exp(1, -32'd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0); drain(50);
        op_exp(1, 32'd100, -32'd7, 32'hFFFFFFF2, 32'd2, 0);     drain(50);
        op_exp(0, 32'h12345678, 32'd0, '1, 32'h12345678, 1);    drain(50);
        op_exp(1, 32'h12345678, 32'd0, '1, 32'h12345678, 1);    drain(50);
        op_exp(1, 32'h80000005, 32'd0, '1, 32'h80000005, 1);    drain(50);
        op_exp(1, MIN, '1, MIN, 32'd0, 0);                      drain(50);
        op_exp(0, MIN, '1, 32'd0, MIN, 0);                      drain(50);
        op_exp(0, 32'd5, 32'd9, 32'd0, 32'd5, 0);               drain(50);
        op_exp(1, 32'd0, 32'd5, 32'd0, 32'd0, 0);               drain(50);
        op_exp(1, -32'd7, -32'd2, 32'd3, 32'hFFFFFFFF, 0);      drain(50);
        op_exp(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0); drain(50);
        op_exp(1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0); drain(50);

        // start mid-ITER must be ignored
        op_exp(0, 32'd1000000, 32'd3, 32'd333333, 32'd1, 0);
        repeat (9) @(negedge clk);
        signed_op = 1'b1;
        dividend = 32'd77;
        divisor = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(50);
        repeat (40) @(negedge clk);

        // back-to-back: second start in the done cycle
        begin
            int n = 0;
            op_exp(0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", {63'b0, done}, 64'd1);
            op_exp(1, -32'd50, 32'd8, -32'd6, -32'd2, 0);
            drain(50);
        end

        // reset at iteration 10 abandons the operation
        op_exp(0, 32'd999, 32'd4, 32'd249, 32'd3, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_quotient", {32'b0, quotient}, 64'd0);
        check("midrst_remainder", {32'b0, remainder}, 64'd0);
        check("midrst_dz", {63'b0, div_by_zero}, 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            bit           s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 8);
                3: b = a >> $urandom_range(0, 31);
                default: b = '0;
            endcase
            start_op(s, a, b, model(s, a, b));
            drain(50);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
Multi-cycle restoring divider, parametrised in operand width, with per-operation signed/unsigned mode. Replaces the combinational divider in the ALU datapath.
- Produces one quotient bit per clock.
- Uses a start/busy/done handshake so the control unit stalls on divide instead of carrying a WIDTH-deep combinational chain.
- Provides quotient, remainder and a packed {remainder, quotient} word for the HI/LO registers.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>= 4).

Ports:
clk  input  1  rising-edge clock, sole clock of the block.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start  input  1  request; accepted only in IDLE.
signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
dividend  input  WIDTH  numerator; sampled with start.
divisor  input  WIDTH  denominator; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse, results valid.
quotient  output  WIDTH  result quotient; holds until next done.
remainder  output  WIDTH  result remainder; holds until next done.
hilo  output  2*WIDTH  {remainder, quotient}.
div_by_zero  output  1  set with done when divisor == 0; holds until next done.

Behaviour:
- Reset: rst_n low at an edge forces IDLE.
  - busy=0, done=0, div_by_zero=0; quotient, remainder and hilo = 0.
  - Any operation in progress is abandoned, and no done is issued for it.
- States: IDLE, ITER, FIX.
- IDLE, start=1 at edge E0:
  - Latch sign_q = signed_op & (dividend[MSB] ^ divisor[MSB]) and sign_r = signed_op & dividend[MSB].
  - Latch magnitudes: two's-complement negate if signed_op and MSB=1, else pass unchanged.
  - Clear accumulator A (WIDTH+1 bits) and counter.
  - busy=1 from E0; go to ITER.
- divisor == 0 at E0: go directly to FIX with the zero flag set.
- ITER: one iteration per edge, WIDTH edges (E1..EWIDTH); counter counts 0..WIDTH-1.
  - Shift {A,Q} left by 1.
  - A = A - M.
  - If A[WIDTH] (sign) = 1: restore A = A + M, Q[0]=0; else Q[0]=1.
  - After the last iteration go to FIX.
- FIX (one edge, EWIDTH+1): register the outputs, then return to IDLE.
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - done=1 for exactly one cycle; busy=0 at the same edge.
- Latency: done visible in the cycle after edge E(WIDTH+1), i.e. WIDTH+1 cycles after the start edge. Divide by zero completes at E1.
- Divide by zero: quotient = all ones, remainder = dividend unmodified, div_by_zero=1.
- Signed most-negative / -1: quotient = most-negative value (wraps), remainder = 0, no flag.
- Truncating semantics: quotient rounds toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- start while busy or in FIX: ignored, no queuing. start in the done cycle (IDLE) is accepted.
- Operand inputs may change freely after E0.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: at E0, if divisor != 0 and |dividend| < |divisor| (unsigned compare of magnitudes), skip ITER and go to FIX.
  - Result: quotient 0, remainder = dividend; done after E1.
  - This also covers dividend == 0.
- Undefined: fixed WIDTH+1 latency for every nonzero divisor. Results are identical either way; only the timing differs.

Test Plan:
1. WIDTH=32, unsigned, 100 / 7 -> done 33 cycles after the start edge; quotient=14, remainder=2, hilo=0x00000002_0000000E, div_by_zero=0.
2. Signed -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100 / -7 -> quotient=-14, remainder=2.
3. Divide by zero: 0x12345678 / 0, signed and unsigned -> done 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
4. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x80000000.
5. Handshake and reset:
   - Pulse start again mid-ITER -> ignored; the result of the first operation is unchanged.
   - Back-to-back start in the done cycle -> second operation accepted.
   - rst_n=0 at iteration 10 -> busy=0 and outputs 0 next cycle, no done pulse.
6. Early-out: with DIV_EARLY_OUT_EN, 5 / 9 -> done 1 cycle after start, quotient=0, remainder=5. Without it -> same values after 33 cycles.
